// File: rtl/qam_tx_pkg.sv
// Shared types and constants for the 16-QAM transmit scheduler.
// Nibble order and idle symbol live here so every user agrees.
package qam_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [3:0] DEF_IDLE_SYMBOL = 4'b0000;
  localparam logic       NIBBLE_HI_FIRST = 1'b1;

  function automatic logic [3:0] pick_nibble(
    input logic [7:0] b,
    input logic       hi
  );
    return hi ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/qam_byte_fifo.sv
// Byte FIFO between the source and the symbol scheduler.
// Show-ahead read port; registered level drives full/empty.
module qam_byte_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rptr];

  // storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // pointers and occupancy, flushed by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/qam_tx_scheduler.sv
// 16-QAM transmit scheduler: byte FIFO, nibble split, SPS hold,
// continuous carrier phase and idle-symbol insertion on underrun.
module qam_tx_scheduler
  import qam_tx_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SPS         = 8,
  parameter int         PHASE_W     = 6,
  parameter int         PHASE_STEP  = 8,
  parameter logic [3:0] IDLE_SYMBOL = DEF_IDLE_SYMBOL,
  localparam int        LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               clr_underrun,
  output logic               mod_start,
  output logic [3:0]         sym_data,
  output logic               sym_strobe,
  output logic               sample_valid,
  output logic [PHASE_W-1:0] phase_addr,
  output logic               busy,
  output logic               underrun,
  output logic [LW-1:0]      fifo_level
);

  localparam int CW = $clog2(SPS);
  localparam logic [PHASE_W-1:0] STEP = PHASE_W'(PHASE_STEP);

  state_t        state;
  state_t        state_next;
  logic [7:0]    shreg;
  logic [7:0]    rdata;
  logic          nib_sel;
  logic          idle_sym;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          last;
  logic          on_first;
  logic          byte_end;
  logic          ur_set;

  assign s_ready  = !full;
  assign push     = s_valid && !full;
  assign last     = (cnt == CW'(SPS - 1));
  assign on_first = (nib_sel == NIBBLE_HI_FIRST);
  assign byte_end = last && (idle_sym || !on_first);
  assign ur_set   = (state == ST_RUN) && byte_end && en && empty;

  qam_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // next state and pop decision at start and byte boundaries
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en && !empty) state_next = ST_START;
      end
      ST_START: begin
        pop        = 1'b1;
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (byte_end) begin
          if (!en) state_next = ST_IDLE;
          else if (!empty) pop = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // state register plus the status outputs aligned with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mod_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      mod_start <= (state_next == ST_START);
      busy      <= (state_next != ST_IDLE);
    end
  end

  // registered sample stream: symbol, strobe and carrier phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg        <= '0;
      nib_sel      <= NIBBLE_HI_FIRST;
      idle_sym     <= 1'b0;
      cnt          <= '0;
      sym_data     <= '0;
      sym_strobe   <= 1'b0;
      sample_valid <= 1'b0;
      phase_addr   <= '0;
    end else if (state == ST_START) begin
      shreg        <= rdata;
      nib_sel      <= NIBBLE_HI_FIRST;
      idle_sym     <= 1'b0;
      cnt          <= '0;
      sym_data     <= pick_nibble(rdata, NIBBLE_HI_FIRST);
      sym_strobe   <= 1'b1;
      sample_valid <= 1'b1;
      phase_addr   <= '0;
    end else if (state == ST_RUN) begin
      if (!last) begin
        cnt        <= cnt + CW'(1);
        sym_strobe <= 1'b0;
        phase_addr <= phase_addr + STEP;
      end else if (!byte_end) begin
        cnt        <= '0;
        nib_sel    <= ~nib_sel;
        sym_data   <= pick_nibble(shreg, ~nib_sel);
        sym_strobe <= 1'b1;
        phase_addr <= phase_addr + STEP;
      end else if (!en) begin
        cnt          <= '0;
        sym_strobe   <= 1'b0;
        sample_valid <= 1'b0;
      end else if (!empty) begin
        shreg      <= rdata;
        nib_sel    <= NIBBLE_HI_FIRST;
        idle_sym   <= 1'b0;
        cnt        <= '0;
        sym_data   <= pick_nibble(rdata, NIBBLE_HI_FIRST);
        sym_strobe <= 1'b1;
        phase_addr <= phase_addr + STEP;
      end else begin
        idle_sym   <= 1'b1;
        cnt        <= '0;
        sym_data   <= IDLE_SYMBOL;
        sym_strobe <= 1'b1;
        phase_addr <= phase_addr + STEP;
      end
    end
  end

  // sticky underrun flag; a new underrun beats a clear
  always_ff @(posedge clk) begin
    if (!rst) underrun <= 1'b0;
    else if (ur_set) underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

endmodule
